// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Register file with two writeback ports (wb0 = ALU/jump,
//            wb1 = load), two combinational read ports and a per-register
//            pending scoreboard that stalls issue on RAW/WAW hazards.
// Ports    : clk, reset (async, active-high)
//            rs1_addr/rs2_addr -> rs1_data/rs2_data  combinational reads
//            issue_valid/uses_rs1/uses_rs2/wr/rd -> issue_ready
//            wb0_en/addr/data, wb1_en/addr/data      writeback ports
//            pending [NREGS]  outstanding-write bitmap
//            wb_err           sticky unexpected-writeback flag
// Option   : REGFILE_BYPASS_EN - forward same-cycle writeback data to the
//            read ports and treat clearing pending bits as already clear.
// Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             issue_valid,
    input  logic             issue_uses_rs1,
    input  logic             issue_uses_rs2,
    input  logic             issue_wr,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic             wb0_en,
    input  logic [AW-1:0]    wb0_addr,
    input  logic [XLEN-1:0]  wb0_data,
    input  logic             wb1_en,
    input  logic [AW-1:0]    wb1_addr,
    input  logic [XLEN-1:0]  wb1_data,
    output logic [NREGS-1:0] pending,
    output logic             wb_err
);

    localparam logic c_zero_en = (ZERO_REG != 0);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic             r_wb_err;

    logic             w_wb0_ok;
    logic             w_wb1_ok;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_pend_eff;
    logic             w_err;

    // A writeback "takes effect" unless it targets the hardwired zero register.
    assign w_wb0_ok = wb0_en && !(c_zero_en && (wb0_addr == '0));
    assign w_wb1_ok = wb1_en && !(c_zero_en && (wb1_addr == '0));

    always_comb begin
        w_clr = '0;
        if (w_wb0_ok) w_clr[wb0_addr] = 1'b1;
        if (w_wb1_ok) w_clr[wb1_addr] = 1'b1;
    end

    // The hazard view deliberately excludes this cycle's set bits, so the
    // ready path never loops back through its own issue decision.
`ifdef REGFILE_BYPASS_EN
    assign w_pend_eff = r_pending & ~w_clr;
`else
    assign w_pend_eff = r_pending;
`endif

    always_comb begin
        issue_ready = 1'b1;
        if (issue_uses_rs1 && w_pend_eff[rs1_addr]) issue_ready = 1'b0;
        if (issue_uses_rs2 && w_pend_eff[rs2_addr]) issue_ready = 1'b0;
        if (issue_wr && w_pend_eff[issue_rd])       issue_ready = 1'b0;
    end

    always_comb begin
        w_set = '0;
        if (issue_valid && issue_ready && issue_wr &&
            !(c_zero_en && (issue_rd == '0)))
            w_set[issue_rd] = 1'b1;
    end

    // Error uses the raw address: any non-zero target that was not pending.
    assign w_err = (wb0_en && (wb0_addr != '0) && !r_pending[wb0_addr]) ||
                   (wb1_en && (wb1_addr != '0) && !r_pending[wb1_addr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            // Set after clear: a new producer stays outstanding.
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_err) r_wb_err <= 1'b1;
        end
    end

    // One storage element per register; wb1 wins a same-address collision.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_regs[i] <= '0;
            end else if (w_wb1_ok && (wb1_addr == AW'(i))) begin
                r_regs[i] <= wb1_data;
            end else if (w_wb0_ok && (wb0_addr == AW'(i))) begin
                r_regs[i] <= wb0_data;
            end
        end
    end

    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs2_data = r_regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (rs1_addr != '0) begin
            if (w_wb1_ok && (wb1_addr == rs1_addr))      rs1_data = wb1_data;
            else if (w_wb0_ok && (wb0_addr == rs1_addr)) rs1_data = wb0_data;
        end
        if (rs2_addr != '0) begin
            if (w_wb1_ok && (wb1_addr == rs2_addr))      rs2_data = wb1_data;
            else if (w_wb0_ok && (wb0_addr == rs2_addr)) rs2_data = wb0_data;
        end
`endif
        if (c_zero_en && (rs1_addr == '0)) rs1_data = '0;
        if (c_zero_en && (rs2_addr == '0)) rs2_data = '0;
    end

    assign pending = r_pending;
    assign wb_err  = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed self-checking bench for regfile_scoreboard. Expected
//            values follow REGFILE_BYPASS_EN when that macro is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_wr;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic [31:0] pending;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_uses_rs1(issue_uses_rs1),
        .issue_uses_rs2(issue_uses_rs2), .issue_wr(issue_wr),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .pending(pending), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_wr = 0;
        issue_rd = 0; wb0_en = 0; wb0_addr = 0; wb0_data = 0;
        wb1_en = 0; wb1_addr = 0; wb1_data = 0;
    endtask

    task automatic apply_reset();
        idle();
        rs1_addr = 0; rs2_addr = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0];
            rs2_addr = 5'(31 - a);
            #1;
            n_vec++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read a=%0d: rs1=%h rs2=%h required 0/0", a, rs1_data, rs2_data);
            end
        end
        n_vec++;
        if (pending !== 32'h0 || issue_ready !== 1'b1 || wb_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: pending=%h ready=%b err=%b required 0/1/0", pending, issue_ready, wb_err);
        end
    endtask

    task automatic test_raw_hazard();
        apply_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL raw_issue_producer: ready=%b required 1", issue_ready);
        end
        tick();
        idle();
        issue_valid = 1; issue_uses_rs1 = 1; rs1_addr = 5;
        #1;
        n_vec++;
        if (issue_ready !== 1'b0 || pending[5] !== 1'b1) begin
            n_err++; $display("FAIL raw_stall: ready=%b pend5=%b required 0/1", issue_ready, pending[5]);
        end
        wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF;
        #1;
        n_vec++;
        if (issue_ready !== c_bypass ||
            rs1_data !== (c_bypass ? 32'hDEADBEEF : 32'h0)) begin
            n_err++; $display("FAIL raw_wb_cycle: ready=%b rs1=%h required %b/%h", issue_ready, rs1_data,
                              c_bypass, c_bypass ? 32'hDEADBEEF : 32'h0);
        end
        tick();
        wb0_en = 0;
        #1;
        n_vec++;
        if (rs1_data !== 32'hDEADBEEF || pending[5] !== 1'b0 || issue_ready !== 1'b1 || wb_err !== 1'b0) begin
            n_err++; $display("FAIL raw_after_wb: rs1=%h pend5=%b ready=%b err=%b required deadbeef/0/1/0",
                              rs1_data, pending[5], issue_ready, wb_err);
        end
        idle();
    endtask

    task automatic test_collision();
        apply_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 7;
        tick();
        idle();
        rs1_addr = 7; rs2_addr = 7;
        wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11111111;
        wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22222222;
        #1;
        n_vec++;
        if (rs2_data !== (c_bypass ? 32'h22222222 : 32'h0)) begin
            n_err++; $display("FAIL collision_fwd: rs2=%h required %h", rs2_data, c_bypass ? 32'h22222222 : 32'h0);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (rs1_data !== 32'h22222222 || rs2_data !== 32'h22222222 || wb_err !== 1'b0 || pending[7] !== 1'b0) begin
            n_err++; $display("FAIL collision: rs1=%h rs2=%h err=%b pend7=%b required 22222222/22222222/0/0",
                              rs1_data, rs2_data, wb_err, pending[7]);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 0;
        wb0_en = 1; wb0_addr = 0; wb0_data = 32'h12345678;
        rs1_addr = 0;
        #1;
        n_vec++;
        if (rs1_data !== 32'h0) begin
            n_err++; $display("FAIL zero_fwd: rs1=%h required 0", rs1_data);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (pending !== 32'h0 || rs1_data !== 32'h0 || wb_err !== 1'b0) begin
            n_err++; $display("FAIL zero_reg: pending=%h rs1=%h err=%b required 0/0/0", pending, rs1_data, wb_err);
        end
    endtask

    task automatic test_waw_set_wins();
        apply_reset();
        issue_valid = 1; issue_wr = 1; issue_rd = 9;
        tick();
        #1;
        n_vec++;
        if (issue_ready !== 1'b0) begin
            n_err++; $display("FAIL waw_block: ready=%b required 0", issue_ready);
        end
        tick();
        n_vec++;
        if (pending !== 32'h0000_0200) begin
            n_err++; $display("FAIL waw_hold: pending=%h required 00000200", pending);
        end
        idle();
        wb1_en = 1; wb1_addr = 9; wb1_data = 32'hAAAA5555;
        tick();
        idle();
        #1;
        n_vec++;
        if (pending[9] !== 1'b0 || wb_err !== 1'b0) begin
            n_err++; $display("FAIL waw_clear: pend9=%b err=%b required 0/0", pending[9], wb_err);
        end
        issue_valid = 1; issue_wr = 1; issue_rd = 9;
        wb1_en = 1; wb1_addr = 9; wb1_data = 32'h00005A5A;
        #1;
        n_vec++;
        if (issue_ready !== 1'b1) begin
            n_err++; $display("FAIL set_wins_ready: ready=%b required 1", issue_ready);
        end
        tick();
        idle();
        rs1_addr = 9;
        #1;
        n_vec++;
        if (pending[9] !== 1'b1 || rs1_data !== 32'h00005A5A || wb_err !== 1'b1) begin
            n_err++; $display("FAIL set_wins: pend9=%b rs1=%h err=%b required 1/00005a5a/1",
                              pending[9], rs1_data, wb_err);
        end
    endtask

    task automatic test_wb_err_reset();
        apply_reset();
        wb0_en = 1; wb0_addr = 3; wb0_data = 32'h00000033;
        rs1_addr = 3;
        #1;
        n_vec++;
        if (wb_err !== 1'b0) begin
            n_err++; $display("FAIL err_early: err=%b required 0", wb_err);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (wb_err !== 1'b1 || rs1_data !== 32'h00000033) begin
            n_err++; $display("FAIL err_set: err=%b rs1=%h required 1/00000033", wb_err, rs1_data);
        end
        issue_valid = 1; issue_wr = 1; issue_rd = 3;
        tick();
        idle();
        #1;
        n_vec++;
        if (pending !== 32'h0000_0008 || wb_err !== 1'b1) begin
            n_err++; $display("FAIL err_sticky: pending=%h err=%b required 00000008/1", pending, wb_err);
        end
        // Mid-cycle reset, no clock edge involved.
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (pending !== 32'h0 || wb_err !== 1'b0 || rs1_data !== 32'h0) begin
            n_err++; $display("FAIL async_reset: pending=%h err=%b rs1=%h required 0/0/0", pending, wb_err, rs1_data);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rs1_addr = 0; rs2_addr = 0;
        test_reset();
        test_raw_hazard();
        test_collision();
        test_zero_reg();
        test_waw_set_wins();
        test_wb_err_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
